// File: rtl/capture_buffered.sv
// Pre/post-trigger sample capture with a FWFT buffer
// streamed out over an AXI-stream master port.
module capture_buffered #(
   parameter int size    = 32,
   parameter int max_div = 32,
   parameter int depth   = 256
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [$clog2(max_div)-1:0] ckdiv,
   input  logic [size-1:0]            dinput,
   input  logic                       trig_in,
   input  logic                       arm,
   input  logic                       abort,
   input  logic [$clog2(depth)-1:0]   pre_count,
   input  logic [31:0]                post_count,
   output logic [size-1:0]            tdata,
   output logic                       tvalid,
   output logic                       tlast,
   input  logic                       tready,
   output logic                       sample_tick,
   output logic                       armed,
   output logic                       triggered,
   output logic                       overrun,
   output logic                       busy
);

   localparam int dw = $clog2(max_div);
   localparam int aw = $clog2(depth);
   localparam logic [aw:0] full_lvl = (aw+1)'(depth);

   typedef enum logic [1:0] {IDLE, FILL, POST, DRAIN} state_t;

   state_t          state, state_nx;
   logic [dw-1:0]   div_cnt, div_q;
   logic [size-1:0] mem [depth];
   logic [aw-1:0]   wptr, rptr;
   logic [aw:0]     occ;
   logic [31:0]     post_cnt, post_lim;
   logic            push, pop, flush, drop, start, trig_hit;

   assign busy        = (state != IDLE);
   assign sample_tick = busy && (div_cnt == div_q);
   assign tvalid      = ((state == POST) || (state == DRAIN)) && (occ != '0);
   assign tlast       = (state == DRAIN) && (occ == (aw+1)'(1));
   assign tdata       = mem[rptr];
   assign post_lim    = (post_count == '0) ? 32'd1 : post_count;

   always_comb begin
      state_nx = state;
      push     = 1'b0;
      pop      = 1'b0;
      flush    = 1'b0;
      drop     = 1'b0;
      start    = 1'b0;
      trig_hit = 1'b0;
      if (abort) begin
         state_nx = IDLE;
         flush    = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (arm) begin
                  state_nx = FILL;
                  flush    = 1'b1;
                  start    = 1'b1;
               end
            end
            FILL: begin
               if (sample_tick) begin
                  push = 1'b1;
                  if (trig_in) begin
                     trig_hit = 1'b1;
                     state_nx = (post_lim <= 32'd1) ? DRAIN : POST;
                  end else if ((occ + (aw+1)'(1)) > {1'b0, pre_count}) begin
                     pop = 1'b1;
                  end
               end
            end
            POST: begin
               pop = tvalid && tready;
               if (sample_tick) begin
                  // a pop in the same cycle frees the slot for this sample
                  if ((occ - {{aw{1'b0}}, pop}) == full_lvl) drop = 1'b1;
                  else push = 1'b1;
                  if ((post_cnt + 32'd1) >= post_lim) state_nx = DRAIN;
               end
            end
            DRAIN: begin
               pop = tvalid && tready;
               if ((occ == '0) || ((occ == (aw+1)'(1)) && pop))
                  state_nx = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= dinput;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         div_cnt   <= '0;
         div_q     <= '0;
         wptr      <= '0;
         rptr      <= '0;
         occ       <= '0;
         post_cnt  <= '0;
         armed     <= 1'b0;
         triggered <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state <= state_nx;
         // new divider value is picked up only when the count wraps
         if (!busy || sample_tick) begin
            div_cnt <= '0;
            div_q   <= ckdiv;
         end else begin
            div_cnt <= div_cnt + dw'(1);
         end
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
         end else begin
            if (push) wptr <= wptr + aw'(1);
            if (pop)  rptr <= rptr + aw'(1);
            occ <= occ + {{aw{1'b0}}, push} - {{aw{1'b0}}, pop};
         end
         if (abort)         armed <= 1'b0;
         else if (start)    armed <= 1'b1;
         else if (trig_hit) armed <= 1'b0;
         if (start)         triggered <= 1'b0;
         else if (trig_hit) triggered <= 1'b1;
         if (start)     overrun <= 1'b0;
         else if (drop) overrun <= 1'b1;
         if (start)         post_cnt <= '0;
         else if (trig_hit) post_cnt <= 32'd1;
         else if ((state == POST) && sample_tick)
            post_cnt <= post_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_capture_buffered.sv
// Directed table and sequence checks for capture_buffered
// with an 8-entry buffer.
module tb_capture_buffered;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ckdiv;
   logic [31:0] dinput;
   logic        trig_in, arm, abort, tready;
   logic [2:0]  pre_count;
   logic [31:0] post_count;
   logic [31:0] tdata;
   logic        tvalid, tlast, sample_tick;
   logic        armed, triggered, overrun, busy;

   always #5 clk = ~clk;

   capture_buffered #(.size(32), .max_div(32), .depth(8)) dut (
      .clk(clk), .reset(reset), .ckdiv(ckdiv), .dinput(dinput),
      .trig_in(trig_in), .arm(arm), .abort(abort),
      .pre_count(pre_count), .post_count(post_count),
      .tdata(tdata), .tvalid(tvalid), .tlast(tlast), .tready(tready),
      .sample_tick(sample_tick), .armed(armed), .triggered(triggered),
      .overrun(overrun), .busy(busy)
   );

   typedef struct packed {
      bit arm; bit abort; bit trig;
      bit tick; bit busy; bit armed; bit trg; bit tv;
   } vec_t;

   vec_t tbl [28];
   int   checks = 0;
   int   errors = 0;
   int   c, ck, trig_k, beat_n, beat_first, exp_n;
   bit   trig_always, tick_chk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic run_cycle();
      c++;
      dinput  = 32'((c + ck) / (ck + 1));
      trig_in = trig_always || (int'(dinput) == trig_k);
      @(negedge clk);
      if (tick_chk && busy)
         chk("tick_phase", {31'd0, sample_tick}, {31'd0, (c % (ck + 1)) == 0});
      if (tvalid && tready) begin
         chk("beat_data", tdata, 32'(beat_first + beat_n));
         chk("beat_last", {31'd0, tlast}, {31'd0, beat_n == exp_n - 1});
         beat_n++;
      end else if (!tvalid) begin
         chk("tlast_no_valid", {31'd0, tlast}, 32'd0);
      end
      @(posedge clk); #1;
   endtask

   task automatic pulse(input bit is_arm);
      if (is_arm) arm = 1'b1; else abort = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      arm   = 1'b0;
      abort = 1'b0;
      c     = 0;
   endtask

   task automatic setup(input int ckv, input int pre, input int post,
                        input bit ta, input int tk, input bit rdy,
                        input int bf, input int en);
      ck = ckv; ckdiv = 5'(ckv);
      pre_count = 3'(pre); post_count = 32'(post);
      trig_always = ta; trig_k = tk; tready = rdy;
      beat_first = bf; exp_n = en; beat_n = 0;
      pulse(1'b1);
   endtask

   task automatic run_until_idle(input string name, input int lim);
      for (int i = 0; i < lim; i++) begin
         if (!busy) break;
         run_cycle();
      end
      chk(name, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // arm abort trig | tick busy armed trg tv   (ckdiv=3, pre=0, post=3)
      tbl[0]  = '{0,0,0, 0,0,0,0,0};
      tbl[1]  = '{1,0,0, 0,0,0,0,0};
      tbl[2]  = '{0,0,0, 0,1,1,0,0};
      tbl[3]  = '{0,0,0, 0,1,1,0,0};
      tbl[4]  = '{0,0,0, 0,1,1,0,0};
      tbl[5]  = '{0,0,0, 1,1,1,0,0};
      tbl[6]  = '{0,0,0, 0,1,1,0,0};
      tbl[7]  = '{0,0,0, 0,1,1,0,0};
      tbl[8]  = '{0,0,0, 0,1,1,0,0};
      tbl[9]  = '{0,0,0, 1,1,1,0,0};
      tbl[10] = '{1,0,0, 0,1,1,0,0};
      tbl[11] = '{0,0,0, 0,1,1,0,0};
      tbl[12] = '{0,0,0, 0,1,1,0,0};
      tbl[13] = '{0,0,0, 1,1,1,0,0};
      tbl[14] = '{1,1,0, 0,1,1,0,0};
      tbl[15] = '{0,0,0, 0,0,0,0,0};
      tbl[16] = '{1,0,0, 0,0,0,0,0};
      tbl[17] = '{0,0,0, 0,1,1,0,0};
      tbl[18] = '{0,0,0, 0,1,1,0,0};
      tbl[19] = '{0,0,0, 0,1,1,0,0};
      tbl[20] = '{0,0,1, 1,1,1,0,0};
      tbl[21] = '{0,0,0, 0,1,0,1,1};
      tbl[22] = '{0,1,0, 0,1,0,1,1};
      tbl[23] = '{0,0,0, 0,0,0,1,0};
      tbl[24] = '{1,0,0, 0,0,0,1,0};
      tbl[25] = '{0,0,0, 0,1,1,0,0};
      tbl[26] = '{0,1,0, 0,1,1,0,0};
      tbl[27] = '{0,0,0, 0,0,0,0,0};

      reset = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0;
      tready = 1'b0; dinput = '0; ckdiv = 5'd3;
      pre_count = 3'd0; post_count = 32'd3;
      trig_always = 1'b0; tick_chk = 1'b0; trig_k = -1;
      c = 0; ck = 3; beat_n = 0; beat_first = 0; exp_n = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 28; i++) begin
         arm = tbl[i].arm; abort = tbl[i].abort; trig_in = tbl[i].trig;
         @(negedge clk);
         chk($sformatf("row%0d_tick", i), {31'd0, sample_tick}, {31'd0, tbl[i].tick});
         chk($sformatf("row%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
         chk($sformatf("row%0d_armed", i), {31'd0, armed}, {31'd0, tbl[i].armed});
         chk($sformatf("row%0d_trig", i), {31'd0, triggered}, {31'd0, tbl[i].trg});
         chk($sformatf("row%0d_tvalid", i), {31'd0, tvalid}, {31'd0, tbl[i].tv});
         chk($sformatf("row%0d_tlast", i), {31'd0, tlast}, 32'd0);
         chk($sformatf("row%0d_ovr", i), {31'd0, overrun}, 32'd0);
         @(posedge clk); #1;
      end
      arm = 1'b0; abort = 1'b0; trig_in = 1'b0;

      // pre=4, post=3, trigger on tick 10: beats 6..12
      tick_chk = 1'b1;
      setup(2, 4, 3, 1'b0, 10, 1'b1, 6, 7);
      run_until_idle("seqA_idle", 200);
      tick_chk = 1'b0;
      chk("seqA_beats", 32'(beat_n), 32'd7);
      chk("seqA_trig", {31'd0, triggered}, 32'd1);
      chk("seqA_armed", {31'd0, armed}, 32'd0);

      // overrun with tready low, then drain of 8 entries
      setup(0, 0, 20, 1'b1, -1, 1'b0, 1, 8);
      repeat (8) run_cycle();
      chk("seqB_ovr_before", {31'd0, overrun}, 32'd0);
      chk("seqB_hold_data", tdata, 32'd1);
      chk("seqB_hold_valid", {31'd0, tvalid}, 32'd1);
      run_cycle();
      chk("seqB_ovr_after", {31'd0, overrun}, 32'd1);
      repeat (11) run_cycle();
      chk("seqB_drain_busy", {31'd0, busy}, 32'd1);
      chk("seqB_drain_tlast", {31'd0, tlast}, 32'd0);
      tready = 1'b1;
      run_until_idle("seqB_idle", 50);
      chk("seqB_beats", 32'(beat_n), 32'd8);
      chk("seqB_ovr_sticky", {31'd0, overrun}, 32'd1);
      chk("seqB_trig", {31'd0, triggered}, 32'd1);

      // full FIFO with simultaneous pop and tick keeps the sample
      setup(0, 0, 20, 1'b1, -1, 1'b0, 1, 9);
      repeat (8) run_cycle();
      tready = 1'b1;
      run_cycle();
      tready = 1'b0;
      chk("seqC_no_ovr", {31'd0, overrun}, 32'd0);
      run_cycle();
      chk("seqC_full_ovr", {31'd0, overrun}, 32'd1);
      repeat (10) run_cycle();
      tready = 1'b1;
      run_until_idle("seqC_idle", 50);
      chk("seqC_beats", 32'(beat_n), 32'd9);

      // abort during POST with 3 entries, then clean re-arm
      setup(0, 0, 20, 1'b1, -1, 1'b0, 1, 99);
      repeat (3) run_cycle();
      chk("seqD_pre_valid", {31'd0, tvalid}, 32'd1);
      abort = 1'b1;
      run_cycle();
      abort = 1'b0;
      chk("seqD_tvalid", {31'd0, tvalid}, 32'd0);
      chk("seqD_busy", {31'd0, busy}, 32'd0);
      chk("seqD_armed", {31'd0, armed}, 32'd0);
      chk("seqD_trig_hold", {31'd0, triggered}, 32'd1);
      trig_always = 1'b0;
      pulse(1'b1);
      chk("seqD_rearm_trig", {31'd0, triggered}, 32'd0);
      chk("seqD_rearm_armed", {31'd0, armed}, 32'd1);
      chk("seqD_rearm_busy", {31'd0, busy}, 32'd1);
      repeat (3) run_cycle();
      chk("seqD_fill_valid", {31'd0, tvalid}, 32'd0);
      pulse(1'b0);
      chk("seqD_abort2", {31'd0, busy}, 32'd0);

      // post_count=0 behaves as 1: one beat with tlast
      setup(0, 0, 0, 1'b1, -1, 1'b1, 1, 1);
      run_until_idle("seqE_idle", 20);
      chk("seqE_beats", 32'(beat_n), 32'd1);
      chk("seqE_trig", {31'd0, triggered}, 32'd1);

      // reset mid-capture drops everything
      setup(0, 0, 20, 1'b1, -1, 1'b0, 1, 0);
      repeat (4) run_cycle();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("seqF_busy", {31'd0, busy}, 32'd0);
      chk("seqF_tvalid", {31'd0, tvalid}, 32'd0);
      chk("seqF_trig", {31'd0, triggered}, 32'd0);
      chk("seqF_armed", {31'd0, armed}, 32'd0);
      chk("seqF_tick", {31'd0, sample_tick}, 32'd0);
      tready = 1'b1;
      beat_n = 0;
      repeat (5) run_cycle();
      chk("seqF_no_beats", 32'(beat_n), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
